// File: rtl/iexecute_pipe_if.sv
// iexecute_pipe_if
// Purpose : groups the ID/EX input handshake and EX/MEM output handshake of
//           the execute stage into one bundle.
// Signals :
//   in_valid/in_ready     ID/EX handshake
//   op, src_a, src_b      decoded operation and operands
//   pc_plus2, br_offset   sequential PC and sign-extended offset
//   jump, jump_back       unconditional redirect / target base is src_a
//   branch_sel, halt_in   branch condition select / HALT marker
//   flush                 discard in-flight and output operation
//   out_valid/out_ready   EX/MEM handshake
//   result, next_pc       registered results
//   redirect, halted      registered taken flag / sticky halt
// Modports: master = producer/consumer side (ID/EX + MEM), slave = stage.
interface iexecute_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] pc_plus2;
  logic [WIDTH-1:0] br_offset;
  logic             jump;
  logic             jump_back;
  logic [2:0]       branch_sel;
  logic             halt_in;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] next_pc;
  logic             redirect;
  logic             halted;

  modport master (
    output in_valid, op, src_a, src_b, pc_plus2, br_offset, jump, jump_back,
           branch_sel, halt_in, flush, out_ready,
    input  in_ready, out_valid, result, next_pc, redirect, halted
  );

  modport slave (
    input  in_valid, op, src_a, src_b, pc_plus2, br_offset, jump, jump_back,
           branch_sel, halt_in, flush, out_ready,
    output in_ready, out_valid, result, next_pc, redirect, halted
  );
endinterface

// File: rtl/iexecute_pipe.sv
// iexecute_pipe
// Purpose : registered execute stage. Computes ALU result, branch/jump target
//           and redirect decision for one operation per handshake; MUL runs a
//           WIDTH-cycle shift-add loop. Supports flush and a sticky halt.
// Ports   :
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   bus   iexecute_pipe_if.slave (ID/EX in, EX/MEM out)
module iexecute_pipe #(
  parameter int WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  iexecute_pipe_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int HW = WIDTH / 2;
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_AND   = 3'd2;
  localparam logic [2:0] OP_OR    = 3'd3;
  localparam logic [2:0] OP_XOR   = 3'd4;
  localparam logic [2:0] OP_SLBI  = 3'd5;
  localparam logic [2:0] OP_MUL   = 3'd6;
  localparam logic [2:0] OP_PASSB = 3'd7;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  // Branch condition on signed src_a; selects 0 and 5-7 never take.
  function automatic logic branch_taken(input logic [2:0] sel,
                                        input logic [WIDTH-1:0] a);
    logic t;
    case (sel)
      3'd1:    t = (a == {WIDTH{1'b0}});
      3'd2:    t = (a != {WIDTH{1'b0}});
      3'd3:    t = a[WIDTH-1];
      3'd4:    t = ~a[WIDTH-1];
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  // Single-cycle ALU; MUL is produced by the iterative loop instead.
  function automatic logic [WIDTH-1:0] alu(input logic [2:0] op,
                                           input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op)
      OP_ADD:   r = a + b;
      OP_SUB:   r = a - b;
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_XOR:   r = a ^ b;
      OP_SLBI:  r = {a[HW-1:0], b[HW-1:0]};
      OP_PASSB: r = b;
      default:  r = {WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mul_a_q, mul_a_d;
  logic [WIDTH-1:0] mul_b_q, mul_b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] next_pc_q, next_pc_d;
  logic             redirect_q, redirect_d;
  logic             out_valid_q, out_valid_d;
  logic             halted_q, halted_d;

  logic             in_ready_s;
  logic             accept_s;
  logic             redirect_s;
  logic [WIDTH-1:0] target_s;
  logic [WIDTH-1:0] next_pc_s;
  logic [WIDTH-1:0] acc_step_s;

  // Output decode: handshake readiness and acceptance (flush blocks acceptance).
  always_comb begin
    in_ready_s = (state_q == ST_IDLE) & ~halted_q & (~out_valid_q | bus.out_ready);
    accept_s   = bus.in_valid & in_ready_s & ~bus.flush;
  end

  // Next-state logic for the IDLE/MUL controller.
  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s && (bus.op == OP_MUL)) begin
            state_d = ST_MUL;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_MUL: begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_MUL;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Redirect decision and target address for the operation being offered.
  always_comb begin
    redirect_s = bus.jump | branch_taken(bus.branch_sel, bus.src_a);
    target_s   = (bus.jump_back ? bus.src_a : bus.pc_plus2) + bus.br_offset;
    next_pc_s  = redirect_s ? target_s : bus.pc_plus2;
    // Partial product for this iteration: add A when the current B LSB is set.
    acc_step_s = acc_q + (mul_b_q[0] ? mul_a_q : {WIDTH{1'b0}});
  end

  // Datapath next values: flush > accept > multiply step > retirement > hold.
  always_comb begin
    cnt_d       = cnt_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    acc_d       = acc_q;
    result_d    = result_q;
    next_pc_d   = next_pc_q;
    redirect_d  = redirect_q;
    out_valid_d = out_valid_q;
    halted_d    = halted_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
      redirect_d  = 1'b0;
      cnt_d       = CNT_ZERO;
    end else if (accept_s) begin
      halted_d   = halted_q | bus.halt_in;
      next_pc_d  = next_pc_s;
      redirect_d = redirect_s;
      if (bus.op == OP_MUL) begin
        mul_a_d     = bus.src_a;
        mul_b_d     = bus.src_b;
        acc_d       = {WIDTH{1'b0}};
        cnt_d       = CNT_ZERO;
        out_valid_d = 1'b0;
      end else begin
        result_d    = alu(bus.op, bus.src_a, bus.src_b);
        out_valid_d = 1'b1;
      end
    end else if (state_q == ST_MUL) begin
      acc_d   = acc_step_s;
      mul_a_d = mul_a_q << 1;
      mul_b_d = mul_b_q >> 1;
      if (cnt_q == CNT_LAST) begin
        result_d    = acc_step_s;
        out_valid_d = 1'b1;
        cnt_d       = CNT_ZERO;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= CNT_ZERO;
      mul_a_q     <= {WIDTH{1'b0}};
      mul_b_q     <= {WIDTH{1'b0}};
      acc_q       <= {WIDTH{1'b0}};
      result_q    <= {WIDTH{1'b0}};
      next_pc_q   <= {WIDTH{1'b0}};
      redirect_q  <= 1'b0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      next_pc_q   <= next_pc_d;
      redirect_q  <= redirect_d;
      out_valid_q <= out_valid_d;
      halted_q    <= halted_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.next_pc   = next_pc_q;
  assign bus.redirect  = redirect_q;
  assign bus.halted    = halted_q;

endmodule

// File: tb/tb_iexecute_pipe.sv
// tb_iexecute_pipe
// Purpose : directed self-checking bench for iexecute_pipe (WIDTH=16).
// Ports   : none (top-level bench).
module tb_iexecute_pipe;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  iexecute_pipe_if #(.WIDTH(16)) bus ();

  iexecute_pipe #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] pc,
                        input logic [15:0] off, input logic jmp,
                        input logic jb, input logic [2:0] bs,
                        input logic hlt);
    bus.in_valid   = 1'b1;
    bus.op         = op;
    bus.src_a      = a;
    bus.src_b      = b;
    bus.pc_plus2   = pc;
    bus.br_offset  = off;
    bus.jump       = jmp;
    bus.jump_back  = jb;
    bus.branch_sel = bs;
    bus.halt_in    = hlt;
  endtask

  // Retire any pending output with no new operation offered.
  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
  endtask

  // Directed stimulus sequence.
  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b0;
    bus.in_valid = 1'b0; bus.op = 3'd0; bus.src_a = 16'h0000; bus.src_b = 16'h0000;
    bus.pc_plus2 = 16'h0000; bus.br_offset = 16'h0000; bus.jump = 1'b0;
    bus.jump_back = 1'b0; bus.branch_sel = 3'd0; bus.halt_in = 1'b0;
    bus.flush = 1'b0; bus.out_ready = 1'b1;
    step(); step();
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_result", {16'd0, bus.result}, 32'h0);
    check("rst_next_pc", {16'd0, bus.next_pc}, 32'h0);
    check("rst_redirect", {31'd0, bus.redirect}, 32'd0);
    check("rst_halted", {31'd0, bus.halted}, 32'd0);
    rst = 1'b1;
    #1;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // ADD wrap into sign bit
    set_op(3'd0, 16'h7FFF, 16'h0001, 16'h0004, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0);
    step();
    bus.in_valid = 1'b0;
    check("add_valid", {31'd0, bus.out_valid}, 32'd1);
    check("add_result", {16'd0, bus.result}, 32'h8000);
    check("add_redirect", {31'd0, bus.redirect}, 32'd0);
    check("add_next_pc", {16'd0, bus.next_pc}, 32'h0004);
    step();
    check("add_retired", {31'd0, bus.out_valid}, 32'd0);

    // Back-to-back ALU ops with out_ready high
    set_op(3'd1, 16'h0005, 16'h0007, 16'h0006, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0);
    step();
    check("sub_result", {16'd0, bus.result}, 32'hFFFE);
    check("b2b_in_ready", {31'd0, bus.in_ready}, 32'd1);
    set_op(3'd2, 16'hF0F0, 16'h0FF0, 16'h0008, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0);
    step();
    check("and_result", {16'd0, bus.result}, 32'h00F0);
    check("and_valid", {31'd0, bus.out_valid}, 32'd1);
    set_op(3'd5, 16'h12AB, 16'h34CD, 16'h000A, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0);
    step();
    check("slbi_result", {16'd0, bus.result}, 32'hABCD);
    set_op(3'd4, 16'hFFFF, 16'h0F0F, 16'h000C, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0);
    step();
    check("xor_result", {16'd0, bus.result}, 32'hF0F0);
    set_op(3'd3, 16'h1200, 16'h0034, 16'h000E, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0);
    step();
    check("or_result", {16'd0, bus.result}, 32'h1234);
    set_op(3'd7, 16'hDEAD, 16'h5A5A, 16'h0010, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0);
    step();
    check("passb_result", {16'd0, bus.result}, 32'h5A5A);
    drain();

    // MUL 3*5: in_ready low for 16 cycles, result 17 edges after accept
    set_op(3'd6, 16'h0003, 16'h0005, 16'h0020, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0);
    step();
    bus.in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("mul_busy_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("mul_busy_valid", {31'd0, bus.out_valid}, 32'd0);
      if (i == 15) bus.in_valid = 1'b0;
      step();
    end
    check("mul_valid", {31'd0, bus.out_valid}, 32'd1);
    check("mul_result", {16'd0, bus.result}, 32'h000F);
    check("mul_next_pc", {16'd0, bus.next_pc}, 32'h0020);
    drain();

    // MUL 0xFFFF*0xFFFF
    set_op(3'd6, 16'hFFFF, 16'hFFFF, 16'h0022, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0);
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 16; i++) step();
    check("mul2_valid", {31'd0, bus.out_valid}, 32'd1);
    check("mul2_result", {16'd0, bus.result}, 32'h0001);
    drain();

    // Branches and jumps
    set_op(3'd0, 16'h8000, 16'h0000, 16'h0010, 16'hFFFC, 1'b0, 1'b0, 3'd3, 1'b0);
    step();
    check("ltz_redirect", {31'd0, bus.redirect}, 32'd1);
    check("ltz_next_pc", {16'd0, bus.next_pc}, 32'h000C);
    set_op(3'd0, 16'h0000, 16'h0000, 16'h0010, 16'hFFFC, 1'b0, 1'b0, 3'd3, 1'b0);
    step();
    check("ltz_nt_redirect", {31'd0, bus.redirect}, 32'd0);
    check("ltz_nt_next_pc", {16'd0, bus.next_pc}, 32'h0010);
    set_op(3'd0, 16'h0000, 16'h0000, 16'h0010, 16'hFFFC, 1'b0, 1'b0, 3'd1, 1'b0);
    step();
    check("eqz_next_pc", {16'd0, bus.next_pc}, 32'h000C);
    set_op(3'd0, 16'h0000, 16'h0000, 16'h0010, 16'hFFFC, 1'b0, 1'b0, 3'd5, 1'b0);
    step();
    check("sel5_redirect", {31'd0, bus.redirect}, 32'd0);
    set_op(3'd0, 16'h0100, 16'h0000, 16'h0010, 16'h0002, 1'b1, 1'b1, 3'd0, 1'b0);
    step();
    check("jr_redirect", {31'd0, bus.redirect}, 32'd1);
    check("jr_next_pc", {16'd0, bus.next_pc}, 32'h0102);
    drain();

    // Backpressure: output held, in_ready low, then same-edge acceptance
    bus.out_ready = 1'b0;
    set_op(3'd0, 16'h0001, 16'h0002, 16'h0030, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0);
    step();
    set_op(3'd1, 16'h0009, 16'h0004, 16'h0032, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_result", {16'd0, bus.result}, 32'h0003);
      check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);
    step();
    bus.in_valid = 1'b0;
    check("bp_next_result", {16'd0, bus.result}, 32'h0005);
    check("bp_next_pc", {16'd0, bus.next_pc}, 32'h0032);
    drain();

    // Flush during MUL iteration 7
    set_op(3'd6, 16'h0003, 16'h0005, 16'h0040, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0);
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("fl_mul_valid", {31'd0, bus.out_valid}, 32'd0);
    check("fl_mul_in_ready", {31'd0, bus.in_ready}, 32'd1);
    for (int i = 0; i < 12; i++) step();
    check("fl_mul_no_emit", {31'd0, bus.out_valid}, 32'd0);

    // Flush coincident with in_valid
    set_op(3'd0, 16'h0001, 16'h0001, 16'h0050, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    check("fl_in_valid", {31'd0, bus.out_valid}, 32'd0);
    step();
    check("fl_in_valid2", {31'd0, bus.out_valid}, 32'd0);

    // Flush clears a held output and redirect
    bus.out_ready = 1'b0;
    set_op(3'd0, 16'h0000, 16'h0000, 16'h0060, 16'h0004, 1'b1, 1'b0, 3'd0, 1'b0);
    step();
    bus.in_valid = 1'b0;
    check("fl_out_pre_redirect", {31'd0, bus.redirect}, 32'd1);
    check("fl_out_pre_next_pc", {16'd0, bus.next_pc}, 32'h0064);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("fl_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("fl_out_redirect", {31'd0, bus.redirect}, 32'd0);
    drain();

    // HALT: result emitted, halted sticky, in_ready low
    set_op(3'd0, 16'h0002, 16'h0002, 16'h0070, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b1);
    step();
    set_op(3'd0, 16'h0009, 16'h0009, 16'h0072, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0);
    check("halt_valid", {31'd0, bus.out_valid}, 32'd1);
    check("halt_result", {16'd0, bus.result}, 32'h0004);
    check("halt_halted", {31'd0, bus.halted}, 32'd1);
    check("halt_in_ready", {31'd0, bus.in_ready}, 32'd0);
    for (int i = 0; i < 4; i++) step();
    check("halt_no_accept_valid", {31'd0, bus.out_valid}, 32'd0);
    check("halt_no_accept_result", {16'd0, bus.result}, 32'h0004);
    check("halt_still_blocked", {31'd0, bus.in_ready}, 32'd0);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    check("halt_after_flush", {31'd0, bus.halted}, 32'd1);
    rst = 1'b0;
    #1;
    check("halt_rst_cleared", {31'd0, bus.halted}, 32'd0);
    step();
    rst = 1'b1;
    #1;
    check("halt_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Reset in the middle of a multiply: nothing emitted
    set_op(3'd6, 16'h0003, 16'h0005, 16'h0080, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0);
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    rst = 1'b0;
    #1;
    check("rstmul_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rstmul_result", {16'd0, bus.result}, 32'h0000);
    step();
    rst = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check("rstmul_no_emit", {31'd0, bus.out_valid}, 32'd0);
    check("rstmul_in_ready", {31'd0, bus.in_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
